req4_rr_arbiter: RTL and testbench

REQ4_RR_ARBITER -- requirements
Module: req4_rr_arbiter

---
 rtl/req4_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_req4_rr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/req4_rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant is issued one cycle after requests are seen in IDLE. It lasts until
// the holder signals done, drops its request or reaches HOLD_MAX cycles. Each
// grant is followed by a one-cycle GAP before the next arbitration.
module req4_rr_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic [7:0] hold_cnt
);

    localparam logic [7:0] HOLD_CNT_MAX = 8'(HOLD_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [3:0] gnt_reg, gnt_next;
    logic [1:0] gnt_id_reg, gnt_id_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;

    // The request vector is rotated so that bit 0 is the requester at ptr.
    // The lowest set bit of the rotated vector is the next winner.
    logic [3:0] rot_req;
    logic [1:0] pick_ofs;
    logic [1:0] pick_id;
    logic       grant_exit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    // Priority-encode the rotated requests (the lowest offset wins).
    always_comb begin
        pick_ofs = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_ofs = 2'(k);
            end
        end
    end

    assign pick_id = ptr_reg + pick_ofs;

    // A grant ends on release, on withdrawal of the holder's request, or on timeout.
    // Several of these can be true together, but the result is still one exit.
    assign grant_exit = done | ~req[gnt_id_reg] | (hold_cnt_reg == HOLD_CNT_MAX);

    // State and registered outputs. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= 2'd0;
            gnt_reg      <= 4'b0000;
            gnt_id_reg   <= 2'd0;
            hold_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Next-state logic: IDLE -> GRANT -> GAP -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req != 4'b0000) state_next = S_GRANT;
            S_GRANT: if (grant_exit)     state_next = S_GAP;
            S_GAP:                       state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
    end

    // Next values of the grant, the hold counter and the pointer.
    // done is only examined in GRANT. Request changes from requesters other
    // than the holder are only considered at the next IDLE arbitration.
    always_comb begin
        ptr_next      = ptr_reg;
        gnt_next      = 4'b0000;
        gnt_id_next   = 2'd0;
        hold_cnt_next = 8'd0;
        case (state_reg)
            S_IDLE: begin
                if (req != 4'b0000) begin
                    gnt_next      = 4'b0001 << pick_id;
                    gnt_id_next   = pick_id;
                    hold_cnt_next = 8'd1;
                end
            end
            S_GRANT: begin
                if (grant_exit) begin
                    ptr_next = gnt_id_reg + 2'd1;
                end else begin
                    gnt_next      = gnt_reg;
                    gnt_id_next   = gnt_id_reg;
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            default: begin
            end
        endcase
    end

    assign gnt      = gnt_reg;
    assign gnt_id   = gnt_id_reg;
    assign gnt_vld  = |gnt_reg;
    assign hold_cnt = hold_cnt_reg;

endmodule

// File: tb/tb_req4_rr_arbiter.sv
// Directed bench for req4_rr_arbiter.
// A table of per-cycle vectors is applied: {rst, req, done} and the outputs
// expected after that edge. A hand-written fairness sequence follows.
// The grant invariants are checked on every falling edge.
module tb_req4_rr_arbiter;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic [7:0] hold_cnt;

    int checks   = 0;
    int failures = 0;
    bit prop_en  = 1'b0;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] exp_gnt;
        logic [1:0] exp_id;
        logic [7:0] exp_hold;
    } vec_t;

    vec_t vecs[$];

    req4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_vld  (gnt_vld),
        .hold_cnt (hold_cnt)
    );

    always #5 clk = ~clk;

    // Append one vector. The expected gnt_id is the index of the one-hot expected grant.
    task automatic add(input string n, input logic r, input logic [3:0] q,
                       input logic d, input logic [3:0] g, input logic [7:0] h);
        vec_t v;
        v.name = n; v.rst = r; v.req = q; v.done = d;
        v.exp_gnt = g; v.exp_hold = h;
        v.exp_id = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
        vecs.push_back(v);
    endtask

    // Grant invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (prop_en) begin
            checks++;
            if (!$onehot0(gnt) || (gnt_vld !== (|gnt)) ||
                (gnt_vld && (gnt !== (4'b0001 << gnt_id))) ||
                (hold_cnt > 8'(HOLD_MAX))) begin
                failures++;
                $display("FAIL prop t=%0t gnt=%b gnt_id=%0d gnt_vld=%b hold_cnt=%0d (need onehot0, vld==|gnt, id match, hold<=%0d)",
                         $time, gnt, gnt_id, gnt_vld, hold_cnt, HOLD_MAX);
            end
        end
    end

    initial begin
        logic [3:0] g;
        logic [1:0] order [4];
        int         seen;
        bit         prev_vld;

        rst = 1'b1; req = 4'b0000; done = 1'b0;

        // A: req=0101 held, timeout-driven alternation 0 -> 2 -> 0
        add("A_rst", 1, 4'b0000, 0, 4'b0000, 0);
        add("A_g0", 0, 4'b0101, 0, 4'b0001, 1);
        for (int h = 2; h <= 8; h++) add("A_g0", 0, 4'b0101, 0, 4'b0001, 8'(h));
        add("A_gap", 0, 4'b0101, 0, 4'b0000, 0);
        add("A_idle", 0, 4'b0101, 0, 4'b0000, 0);
        for (int h = 1; h <= 8; h++) add("A_g2", 0, 4'b0101, 0, 4'b0100, 8'(h));
        add("A_gap", 0, 4'b0101, 0, 4'b0000, 0);
        add("A_idle", 0, 4'b0101, 0, 4'b0000, 0);
        add("A_g0b", 0, 4'b0101, 0, 4'b0001, 1);

        // B: all requesting, done pulsed in the third grant cycle -> order 0,1,2,3,0
        add("B_rst", 1, 4'b0000, 0, 4'b0000, 0);
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << order[k % 4];
            add("B_h1", 0, 4'b1111, 0, g, 1);
            add("B_h2", 0, 4'b1111, 0, g, 2);
            add("B_h3", 0, 4'b1111, 0, g, 3);
            add("B_gap", 0, 4'b1111, 1, 4'b0000, 0);
            add("B_idle", 0, 4'b1111, 0, 4'b0000, 0);
        end

        // C: holder 2 drops its request, and other requests change mid-grant
        add("C_rst_prio", 1, 4'b1111, 1, 4'b0000, 0);
        add("C_g2", 0, 4'b0100, 0, 4'b0100, 1);
        add("C_others", 0, 4'b1111, 0, 4'b0100, 2);
        add("C_drop", 0, 4'b1011, 0, 4'b0000, 0);
        add("C_idle", 0, 4'b1011, 0, 4'b0000, 0);
        add("C_g3", 0, 4'b1011, 0, 4'b1000, 1);
        add("C_rst", 1, 4'b0000, 0, 4'b0000, 0);
        add("C_g2w", 0, 4'b0100, 0, 4'b0100, 1);
        add("C_dropw", 0, 4'b0001, 0, 4'b0000, 0);
        add("C_idlew", 0, 4'b0001, 0, 4'b0000, 0);
        add("C_wrap0", 0, 4'b0001, 0, 4'b0001, 1);

        // D: holder 3 gets done together with timeout -> one GAP, ptr=0.
        //    done is also held through GAP and IDLE, where it must be ignored.
        add("D_rst", 1, 4'b0000, 0, 4'b0000, 0);
        for (int h = 1; h <= 8; h++) add("D_g3", 0, 4'b1000, 0, 4'b1000, 8'(h));
        add("D_gap", 0, 4'b1001, 1, 4'b0000, 0);
        add("D_idle", 0, 4'b1001, 1, 4'b0000, 0);
        add("D_g0", 0, 4'b1001, 1, 4'b0001, 1);
        add("D_g0h2", 0, 4'b1001, 0, 4'b0001, 2);

        // E: reset in the middle of a grant, then arbitration restarts from 0
        add("E_rst", 1, 4'b0000, 0, 4'b0000, 0);
        add("E_g2", 0, 4'b0100, 0, 4'b0100, 1);
        add("E_g2h2", 0, 4'b0100, 0, 4'b0100, 2);
        add("E_midrst", 1, 4'b0100, 0, 4'b0000, 0);
        add("E_g1", 0, 4'b0110, 0, 4'b0010, 1);

        foreach (vecs[i]) begin
            rst  = vecs[i].rst;
            req  = vecs[i].req;
            done = vecs[i].done;
            @(posedge clk);
            #1;
            prop_en = 1'b1;
            checks++;
            if ((gnt !== vecs[i].exp_gnt) || (gnt_vld !== (|vecs[i].exp_gnt)) ||
                (hold_cnt !== vecs[i].exp_hold) ||
                (((|vecs[i].exp_gnt) || vecs[i].rst) && (gnt_id !== vecs[i].exp_id))) begin
                failures++;
                $display("FAIL %s vec=%0d got gnt=%b id=%0d vld=%b hold=%0d need gnt=%b id=%0d vld=%b hold=%0d",
                         vecs[i].name, i, gnt, gnt_id, gnt_vld, hold_cnt,
                         vecs[i].exp_gnt, vecs[i].exp_id, |vecs[i].exp_gnt, vecs[i].exp_hold);
            end else begin
                $display("vec %0d %s rst=%b req=%b done=%b -> gnt=%b id=%0d hold=%0d ok",
                         i, vecs[i].name, vecs[i].rst, vecs[i].req, vecs[i].done,
                         gnt, gnt_id, hold_cnt);
            end
        end

        // Fairness: 0, 1 and 3 request continuously, so the grant order must be 0,1,3,0.
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b1011;
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0;
        seen = 0;
        prev_vld = 1'b0;
        for (int cyc = 0; cyc < 200 && seen < 4; cyc++) begin
            @(posedge clk); #1;
            if (gnt_vld && !prev_vld) begin
                checks++;
                if (gnt_id !== order[seen]) begin
                    failures++;
                    $display("FAIL fair grant#%0d got id=%0d need id=%0d", seen, gnt_id, order[seen]);
                end else begin
                    $display("fair grant#%0d id=%0d ok", seen, gnt_id);
                end
                seen++;
            end
            prev_vld = gnt_vld;
        end
        checks++;
        if (seen < 4) begin
            failures++;
            $display("FAIL fair_timeout got %0d grants need 4 within 200 cycles", seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
